// File: rtl/btn_cmd_conditioner_pkg.sv
// Shared game definitions: button indices, default channel count, drop counter width.
// Also holds the saturating add used by the drop counter.
package btn_cmd_conditioner_pkg;

    typedef enum int {
        BTN_L = 0,
        BTN_R = 1,
        BTN_U = 2,
        BTN_D = 3
    } btn_idx_e;

    localparam int NUM_BTN_DEF = 4;
    localparam int DROP_W      = 8;

    function automatic logic [DROP_W-1:0] sat_add(input logic [DROP_W-1:0] a,
                                                  input logic [DROP_W-1:0] b);
        logic [DROP_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[DROP_W] ? {DROP_W{1'b1}} : s[DROP_W-1:0];
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchroniser, tick-sampled history, debounced level and rise.
// Level updates in the tick_d cycle; rise is a tick_d-cycle pulse; no backpressure.
module btn_debounce_ch #(
    parameter int DEB_DEPTH = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic tick_d,
    input  logic btn,
    output logic level,
    output logic level_nxt,
    output logic rise
);

    logic [1:0]           sync;
    logic [DEB_DEPTH-1:0] hist;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync  <= '0;
            hist  <= '0;
            level <= 1'b0;
        end else begin
            sync <= {sync[0], btn};
            if (tick) begin
                hist <= {hist[DEB_DEPTH-2:0], sync[1]};
            end
            if (tick_d) begin
                level <= level_nxt;
            end
        end
    end

    // A mixed history keeps the previous level.
    always_comb begin
        level_nxt = level;
        if (&hist) begin
            level_nxt = 1'b1;
        end else if (~|hist) begin
            level_nxt = 1'b0;
        end
    end

    assign rise = tick_d & level_nxt & ~level;

endmodule

// File: rtl/btn_cmd_conditioner.sv
// N-channel button front end: debounce, press/repeat events, priority pick, 1-entry cmd buffer.
// cmd_valid rises 2 cycles after the completing tick; events arriving while the buffer is held are counted in drop_cnt.
module btn_cmd_conditioner
    import btn_cmd_conditioner_pkg::*;
#(
    parameter int NUM_BTN       = NUM_BTN_DEF,
    parameter int SAMPLE_PERIOD = 131072,
    parameter int DEB_DEPTH     = 3,
    parameter int REPEAT_DLY    = 40,
    parameter int REPEAT_RATE   = 8,
    localparam int CW           = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn,
    input  logic               mode_repeat,
    input  logic               cmd_ready,
    output logic               cmd_valid,
    output logic [CW-1:0]      cmd_id,
    output logic               cmd_rpt,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [DROP_W-1:0]  drop_cnt
);

    localparam int TW  = $clog2(SAMPLE_PERIOD);
    localparam int TMW = $clog2(REPEAT_DLY + REPEAT_RATE + 1);
    localparam int EW  = $clog2(NUM_BTN + 2);

    localparam logic [TW-1:0]  TICK_LAST = TW'(SAMPLE_PERIOD - 1);
    localparam logic [TMW-1:0] T_DLY     = TMW'(REPEAT_DLY);
    localparam logic [TMW-1:0] T_TOP     = TMW'(REPEAT_DLY + REPEAT_RATE);

    logic [TW-1:0]      tick_cnt;
    logic               tick;
    logic               tick_d;

    logic [NUM_BTN-1:0] level_nxt;
    logic [NUM_BTN-1:0] rise;

    logic               press_any;
    logic [CW-1:0]      win;
    logic [EW-1:0]      n_press;

    logic [CW-1:0]      act;
    logic               armed;
    logic [TMW-1:0]     tmr;
    logic [TMW-1:0]     tmr_inc;
    logic               rpt_go;
    logic               rpt_fire;

    logic               buf_open;
    logic               ev_vld;
    logic [CW-1:0]      ev_id;
    logic               ev_rpt;
    logic [EW-1:0]      n_ev;
    logic [DROP_W-1:0]  drop_inc;

    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
            tick_d   <= 1'b0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
            tick_d   <= tick;
        end
    end

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
        btn_debounce_ch #(
            .DEB_DEPTH (DEB_DEPTH)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .tick      (tick),
            .tick_d    (tick_d),
            .btn       (btn[g]),
            .level     (btn_level[g]),
            .level_nxt (level_nxt[g]),
            .rise      (rise[g])
        );
    end

    // Lowest index wins; every other simultaneous press is a drop.
    always_comb begin
        press_any = |rise;
        win       = '0;
        n_press   = '0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (rise[i]) begin
                win = CW'(i);
            end
        end
        for (int i = 0; i < NUM_BTN; i++) begin
            n_press = n_press + EW'(rise[i]);
        end
    end

    // Hold is judged on the level being committed this tick_d, so a release never repeats.
    always_comb begin
        rpt_go   = armed & mode_repeat & level_nxt[act];
        tmr_inc  = tmr + TMW'(1);
        rpt_fire = tick_d & rpt_go & ((tmr_inc == T_DLY) | (tmr_inc == T_TOP));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            act   <= '0;
            armed <= 1'b0;
            tmr   <= '0;
        end else if (tick_d) begin
            if (press_any && buf_open) begin
                act   <= win;
                armed <= 1'b1;
                tmr   <= '0;
            end else if (!rpt_go) begin
                armed <= 1'b0;
                tmr   <= '0;
            end else if (tmr_inc == T_TOP) begin
                tmr <= T_DLY;
            end else begin
                tmr <= tmr_inc;
            end
        end
    end

    // A press beats a coincident repeat; when the buffer is held, every event is dropped.
    always_comb begin
        buf_open = ~cmd_valid | cmd_ready;
        ev_vld   = press_any | rpt_fire;
        ev_id    = press_any ? win : act;
        ev_rpt   = ~press_any;
        n_ev     = n_press + EW'(rpt_fire);
        drop_inc = '0;
        if (ev_vld) begin
            drop_inc = buf_open ? DROP_W'(n_ev - EW'(1)) : DROP_W'(n_ev);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_valid <= 1'b0;
            cmd_id    <= '0;
            cmd_rpt   <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            if (ev_vld && buf_open) begin
                cmd_valid <= 1'b1;
                cmd_id    <= ev_id;
                cmd_rpt   <= ev_rpt;
            end else if (cmd_ready) begin
                cmd_valid <= 1'b0;
            end
            drop_cnt <= sat_add(drop_cnt, drop_inc);
        end
    end

endmodule
